// File: rtl/amber48_uart_rx.sv
// 8N1 UART receiver: synchronises rx_i, samples each bit at its centre and hands bytes
// out on a valid/ready interface, flagging framing errors and overruns as one-cycle pulses.
module amber48_uart_rx #(
  parameter int CLOCK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE     = 115_200
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       framing_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_baud
      $fatal(1, "amber48_uart_rx: CLKS_PER_BIT must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HI
  } state_e;

  state_e             state_q, state_d;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               deliver_q, deliver_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
  logic               ovr_q, ovr_d;
  logic               rx_s;

  assign rx_s = sync2_q;

  always_comb begin
    sync1_d   = rx_i;
    sync2_d   = sync1_q;
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    deliver_d = 1'b0;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    data_d    = data_q;
    valid_d   = valid_q;

    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        // A start bit that is gone by mid-bit is treated as line noise.
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          if (!rx_s) begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d   = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d          = '0;
          shreg_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            deliver_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            ferr_d    = 1'b1;
            state_d   = S_WAIT_HI;
          end
        end
      end
      S_WAIT_HI: begin
        // Hold off until the line returns high so a break cannot restart a frame.
        clk_cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        clk_cnt_d = '0;
        state_d   = S_IDLE;
      end
    endcase

    if (valid_q && ready_i) valid_d = 1'b0;

    // A byte accepted in the same cycle frees the holding register for the new one.
    if (deliver_q) begin
      if (!valid_q || ready_i) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        ovr_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'h00;
      deliver_q <= 1'b0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      deliver_q <= deliver_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data_o        = data_q;
  assign valid_o       = valid_q;
  assign framing_err_o = ferr_q;
  assign overrun_o     = ovr_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_amber48_uart_rx.sv
// Bench for amber48_uart_rx at 1 Mbaud on a 100 MHz clock; a scoreboard queue holds
// the bytes each scenario expects and a monitor pops them as the receiver hands them out.
module tb_amber48_uart_rx;

  localparam int CPB = 100;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       rx_i;
  logic       ready_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       framing_err_o;
  logic       overrun_o;
  logic       busy_o;

  int checks   = 0;
  int errors   = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int recv_cnt = 0;
  logic [7:0] exp_q[$];

  amber48_uart_rx #(
    .CLOCK_FREQ_HZ(100_000_000),
    .BAUD_RATE    (1_000_000)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rx_i         (rx_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .framing_err_o(framing_err_o),
    .overrun_o    (overrun_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard monitor: every accepted byte must match the oldest expected one.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (framing_err_o) ferr_cnt++;
      if (overrun_o)     ovr_cnt++;
      if (valid_o && ready_i) begin
        logic [7:0] exp_b;
        checks++;
        recv_cnt++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte got %02h required none", data_o);
        end else begin
          exp_b = exp_q.pop_front();
          if (data_o !== exp_b) begin
            errors++;
            $display("FAIL rx_byte got %02h required %02h", data_o, exp_b);
          end
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    rx_i = b;
    repeat (CPB) @(posedge clk_i);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk_i);
      n++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; rx_i = 1'b1; ready_i = 1'b1;
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    checks++; if (data_o !== 8'h00)      begin errors++; $display("FAIL reset_data got %02h required 00", data_o); end
    checks++; if (valid_o !== 1'b0)      begin errors++; $display("FAIL reset_valid got %b required 0", valid_o); end
    checks++; if (framing_err_o !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b required 0", framing_err_o); end
    checks++; if (overrun_o !== 1'b0)    begin errors++; $display("FAIL reset_ovr got %b required 0", overrun_o); end
    checks++; if (busy_o !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b required 0", busy_o); end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (10) @(posedge clk_i); #1;
  endtask

  task automatic test_single();
    int f0 = ferr_cnt, o0 = ovr_cnt, r0 = recv_cnt;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    wait_drain();
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    checks++; if (exp_q.size() != 0)     begin errors++; $display("FAIL single_drain got %0d pending required 0", exp_q.size()); end
    checks++; if (recv_cnt - r0 != 1)    begin errors++; $display("FAIL single_count got %0d required 1", recv_cnt - r0); end
    checks++; if (ferr_cnt != f0 || ovr_cnt != o0) begin errors++; $display("FAIL single_flags got ferr %0d ovr %0d required 0 0", ferr_cnt - f0, ovr_cnt - o0); end
    checks++; if (busy_o !== 1'b0)       begin errors++; $display("FAIL single_busy got %b required 0", busy_o); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg [4];
    int f0 = ferr_cnt, o0 = ovr_cnt, r0 = recv_cnt;
    msg = '{8'h50, 8'h41, 8'h53, 8'h53};
    for (int i = 0; i < 4; i++) exp_q.push_back(msg[i]);
    for (int i = 0; i < 4; i++) send_frame(msg[i], 1'b1);
    wait_drain();
    @(negedge clk_i);
    checks++; if (recv_cnt - r0 != 4)    begin errors++; $display("FAIL b2b_count got %0d required 4", recv_cnt - r0); end
    checks++; if (ferr_cnt != f0 || ovr_cnt != o0) begin errors++; $display("FAIL b2b_flags got ferr %0d ovr %0d required 0 0", ferr_cnt - f0, ovr_cnt - o0); end
  endtask

  task automatic test_framing();
    int f0 = ferr_cnt, o0 = ovr_cnt, r0 = recv_cnt;
    send_frame(8'hA5, 1'b0);
    rx_i = 1'b0;
    repeat (300) @(posedge clk_i); #1;
    rx_i = 1'b1;
    repeat (2 * CPB) @(posedge clk_i); #1;
    @(negedge clk_i);
    checks++; if (ferr_cnt - f0 != 1)    begin errors++; $display("FAIL framing_pulse got %0d required 1", ferr_cnt - f0); end
    checks++; if (recv_cnt != r0)        begin errors++; $display("FAIL framing_discard got %0d bytes required 0", recv_cnt - r0); end
    @(posedge clk_i); #1;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_drain();
    @(negedge clk_i);
    checks++; if (recv_cnt - r0 != 1)    begin errors++; $display("FAIL framing_next got %0d bytes required 1", recv_cnt - r0); end
    checks++; if (ferr_cnt - f0 != 1 || ovr_cnt != o0) begin errors++; $display("FAIL framing_flags got ferr %0d ovr %0d required 1 0", ferr_cnt - f0, ovr_cnt - o0); end
  endtask

  task automatic test_glitch();
    int f0 = ferr_cnt, o0 = ovr_cnt, r0 = recv_cnt;
    int n = 0;
    logic saw_busy = 1'b0;
    rx_i = 1'b0;
    repeat (30) begin
      @(posedge clk_i); #1;
      if (busy_o) saw_busy = 1'b1;
    end
    rx_i = 1'b1;
    while (busy_o && n < 52) begin
      @(posedge clk_i); #1;
      n++;
    end
    checks++; if (saw_busy !== 1'b1)     begin errors++; $display("FAIL glitch_start got busy %b required 1", saw_busy); end
    checks++; if (busy_o !== 1'b0)       begin errors++; $display("FAIL glitch_busy got %b after %0d cycles required 0", busy_o, n); end
    repeat (2 * CPB) @(posedge clk_i);
    @(negedge clk_i);
    checks++; if (recv_cnt != r0 || valid_o !== 1'b0) begin errors++; $display("FAIL glitch_valid got %0d bytes valid %b required 0 0", recv_cnt - r0, valid_o); end
    checks++; if (ferr_cnt != f0 || ovr_cnt != o0) begin errors++; $display("FAIL glitch_flags got ferr %0d ovr %0d required 0 0", ferr_cnt - f0, ovr_cnt - o0); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_overrun();
    int f0 = ferr_cnt, o0 = ovr_cnt;
    ready_i = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (CPB) @(posedge clk_i);
    @(negedge clk_i);
    checks++; if (valid_o !== 1'b1)      begin errors++; $display("FAIL ovr_valid got %b required 1", valid_o); end
    checks++; if (data_o !== 8'h11)      begin errors++; $display("FAIL ovr_hold got %02h required 11", data_o); end
    checks++; if (ovr_cnt - o0 != 1 || ferr_cnt != f0) begin errors++; $display("FAIL ovr_pulse got ovr %0d ferr %0d required 1 0", ovr_cnt - o0, ferr_cnt - f0); end
    @(posedge clk_i); #1;
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    @(negedge clk_i);
    checks++; if (valid_o !== 1'b0)      begin errors++; $display("FAIL ovr_accept got valid %b required 0", valid_o); end
    checks++; if (exp_q.size() != 0)     begin errors++; $display("FAIL ovr_drain got %0d pending required 0", exp_q.size()); end
    @(posedge clk_i); #1;
    ready_i = 1'b1;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b = 8'h99;
    int f0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    rx_i = b[4];
    repeat (CPB / 2) @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0 || data_o !== 8'h00 || framing_err_o !== 1'b0 || overrun_o !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs got busy %b valid %b data %02h ferr %b ovr %b required all 0", busy_o, valid_o, data_o, framing_err_o, overrun_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    rx_i  = 1'b1;
    repeat (2 * CPB) @(posedge clk_i); #1;
    f0 = ferr_cnt;
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    wait_drain();
    repeat (CPB) @(posedge clk_i);
    @(negedge clk_i);
    checks++; if (exp_q.size() != 0)     begin errors++; $display("FAIL midreset_rx got %0d pending required 0", exp_q.size()); end
    checks++; if (ferr_cnt != f0)        begin errors++; $display("FAIL midreset_ferr got %0d required 0", ferr_cnt - f0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_framing();
    test_glitch();
    test_overrun();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
